// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue: issue FSM encodings and defaults.
package uart_pkg;

   localparam int DEFAULT_DEPTH = 16;

   typedef logic [7:0] byte_t;

   // Issue state machine encodings
   localparam logic [1:0] ST_IDLE       = 2'b00;
   localparam logic [1:0] ST_WAIT_START = 2'b01;
   localparam logic [1:0] ST_WAIT_DONE  = 2'b10;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO: storage, wrapping pointers, explicit occupancy count.
// Head data is presented combinationally from the read pointer (no fall-through:
// a push into an empty FIFO becomes visible only after the clock edge).
module sync_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             i_Clock,
   input  logic             i_Rst_n,
   input  logic             i_Wr_En,
   input  logic [WIDTH-1:0] i_Wr_Data,
   input  logic             i_Rd_En,
   output logic [WIDTH-1:0] o_Rd_Data,
   output logic             o_Full,
   output logic             o_Empty,
   output logic [CW-1:0]    o_Count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push, pop;

   assign o_Full    = (count_q == CW'(DEPTH));
   assign o_Empty   = (count_q == '0);
   assign o_Count   = count_q;
   assign o_Rd_Data = mem_q[rd_ptr_q];

   // Accepted push/pop and next pointer/count; pointers wrap on their own width
   always_comb begin
      push     = i_Wr_En && !o_Full;
      pop      = i_Rd_En && !o_Empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers with synchronous active-low reset
   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset
   always_ff @(posedge i_Clock) begin
      if (push) mem_q[wr_ptr_q] <= i_Wr_Data;
   end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of a UART transmitter. Buffers pushed bytes and issues
// them one at a time with a single-cycle DV pulse, then waits for the
// transmitter's active/done handshake before issuing the next one.
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter  int DEPTH = DEFAULT_DEPTH,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          i_Clock,
   input  logic          i_Rst_n,
   input  logic          i_Wr_DV,
   input  logic [7:0]    i_Wr_Byte,
   output logic          o_Full,
   output logic          o_Empty,
   output logic [CW-1:0] o_Count,
   output logic          o_Overflow,
   output logic          o_Tx_DV,
   output logic [7:0]    o_Tx_Byte,
   input  logic          i_Tx_Active,
   input  logic          i_Tx_Done
);

   logic [1:0] state_q, state_d;
   logic       tx_dv_q, tx_dv_d;
   byte_t      tx_byte_q, tx_byte_d;
   logic       overflow_q, overflow_d;
   byte_t      head_byte;
   logic       fifo_full, fifo_empty;
   logic       pop;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .i_Clock   (i_Clock),
      .i_Rst_n   (i_Rst_n),
      .i_Wr_En   (i_Wr_DV),
      .i_Wr_Data (i_Wr_Byte),
      .i_Rd_En   (pop),
      .o_Rd_Data (head_byte),
      .o_Full    (fifo_full),
      .o_Empty   (fifo_empty),
      .o_Count   (o_Count)
   );

   assign o_Full     = fifo_full;
   assign o_Empty    = fifo_empty;
   assign o_Overflow = overflow_q;
   assign o_Tx_DV    = tx_dv_q;
   assign o_Tx_Byte  = tx_byte_q;

   // Issue FSM: pop only when the transmitter is neither busy nor still
   // flagging done, which also covers a transmitter left busy across our reset
   always_comb begin
      state_d    = state_q;
      tx_dv_d    = 1'b0;
      tx_byte_d  = tx_byte_q;
      pop        = 1'b0;
      // A push against a full FIFO is lost even if a pop frees a slot this cycle
      overflow_d = overflow_q | (i_Wr_DV & fifo_full);
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && !i_Tx_Active && !i_Tx_Done) begin
               pop       = 1'b1;
               tx_dv_d   = 1'b1;
               tx_byte_d = head_byte;
               state_d   = ST_WAIT_START;
            end
         end
         ST_WAIT_START: if (i_Tx_Active) state_d = ST_WAIT_DONE;
         ST_WAIT_DONE:  if (i_Tx_Done)   state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
   end

   // Output and state registers with synchronous active-low reset
   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         state_q    <= ST_IDLE;
         tx_dv_q    <= 1'b0;
         tx_byte_q  <= 8'h00;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_dv_q    <= tx_dv_d;
         tx_byte_q  <= tx_byte_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a behavioural transmitter (4 clocks/bit).
module tb_uart_tx_queue;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_dv = 1'b0;
   logic [7:0] wr_byte = 8'h00;
   logic       full, empty, ovf, tx_dv;
   logic [4:0] count;
   logic [7:0] tx_byte;
   logic       tx_act = 1'b0;
   logic       tx_done = 1'b0;
   logic       tx_line = 1'b1;
   logic       hold_busy = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   uart_tx_queue #(.DEPTH(16)) dut (
      .i_Clock     (clk),
      .i_Rst_n     (rst_n),
      .i_Wr_DV     (wr_dv),
      .i_Wr_Byte   (wr_byte),
      .o_Full      (full),
      .o_Empty     (empty),
      .o_Count     (count),
      .o_Overflow  (ovf),
      .o_Tx_DV     (tx_dv),
      .o_Tx_Byte   (tx_byte),
      .i_Tx_Active (tx_act),
      .i_Tx_Done   (tx_done)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Transmitter model: start on DV, 10 bits of CPB clocks, then Done for 2 cycles
   int         m_state = 0;
   int         m_cnt = 0;
   int         m_bit = 0;
   logic [9:0] m_frame = '0;
   always @(posedge clk) begin
      case (m_state)
         0: begin
            tx_done <= 1'b0;
            tx_act  <= hold_busy;
            tx_line <= 1'b1;
            if (tx_dv && !hold_busy) begin
               m_state <= 1;
               tx_act  <= 1'b1;
               m_frame <= {1'b1, tx_byte, 1'b0};
               tx_line <= 1'b0;
               m_cnt   <= 0;
               m_bit   <= 0;
            end
         end
         1: begin
            if (m_cnt == CPB - 1) begin
               m_cnt <= 0;
               if (m_bit == 9) begin
                  m_state <= 2;
                  tx_act  <= 1'b0;
                  tx_done <= 1'b1;
                  tx_line <= 1'b1;
               end else begin
                  m_bit   <= m_bit + 1;
                  tx_line <= m_frame[m_bit + 1];
               end
            end else m_cnt <= m_cnt + 1;
         end
         2: m_state <= 3;
         default: begin
            m_state <= 0;
            tx_done <= 1'b0;
         end
      endcase
   end

   // Monitors: serial bits at mid-bit, issued bytes, DV legality
   logic   bits_q[$];
   logic [7:0] iss_q[$];
   logic [4:0] cnt_q[$];
   logic   fall_q[$];
   logic   prev_done = 1'b0;
   logic   prev_dv = 1'b0;
   logic   saw_fall = 1'b0;

   always @(negedge clk) begin
      if (m_state == 1 && m_cnt == 2) bits_q.push_back(tx_line);
      if (tx_dv) begin
         chk("dv_while_tx_busy", {30'd0, tx_act, tx_done}, 32'd0);
         iss_q.push_back(tx_byte);
         cnt_q.push_back(count);
         fall_q.push_back(saw_fall);
      end
      if (prev_dv) chk("dv_single_pulse", tx_dv, 1'b0);
      if (prev_done && !tx_done) saw_fall <= 1'b1;
      else if (tx_dv)            saw_fall <= 1'b0;
      prev_done <= tx_done;
      prev_dv   <= tx_dv;
   end

   task automatic clear_logs();
      bits_q.delete(); iss_q.delete(); cnt_q.delete(); fall_q.delete();
   endtask

   // Wait until n bytes issued and transmitter fully idle, within a cycle budget
   task automatic wait_idle(input int n, input int budget, input string nm);
      int k = 0;
      while (k < budget && !(iss_q.size() >= n && m_state == 0 && !tx_done && !tx_act && !tx_dv)) begin
         @(negedge clk);
         k++;
      end
      chk(nm, (k < budget), 1'b1);
   endtask

   typedef struct {
      logic       wr_dv;
      logic [7:0] wr_byte;
      logic [4:0] exp_count;
      logic       exp_full;
      logic       exp_empty;
      logic       exp_ovf;
   } vec_t;
   vec_t vecs[18];

   initial begin
      logic [9:0] got_bits;
      int k;

      // Fill level / overflow vectors: 17 pushes into a DEPTH=16 FIFO, then a hold
      for (int i = 0; i < 17; i++)
         vecs[i] = '{1'b1, 8'h20 + 8'(i), (i < 16) ? 5'(i + 1) : 5'd16,
                     (i >= 15), 1'b0, (i == 16)};
      vecs[17] = '{1'b0, 8'hEE, 5'd16, 1'b1, 1'b0, 1'b1};

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_count", count, 5'd0);
      chk("rst_dv", tx_dv, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_tx_byte", tx_byte, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);

      // Single byte: 2-cycle push-to-DV latency and serial frame
      wr_dv = 1'b1; wr_byte = 8'hA5;
      @(negedge clk);
      wr_dv = 1'b0;
      chk("single_count_after_push", count, 5'd1);
      chk("single_empty_after_push", empty, 1'b0);
      chk("single_no_fallthrough", tx_dv, 1'b0);
      @(negedge clk);
      chk("single_dv", tx_dv, 1'b1);
      chk("single_byte", tx_byte, 8'hA5);
      chk("single_count_after_pop", count, 5'd0);
      @(negedge clk);
      chk("single_byte_stable", tx_byte, 8'hA5);
      wait_idle(1, 200, "single_wait");
      chk("single_issued_n", iss_q.size(), 1);
      chk("single_nbits", bits_q.size(), 10);
      got_bits = '0;
      for (int i = 0; i < 10 && i < bits_q.size(); i++) got_bits[i] = bits_q[i];
      chk("single_serial", got_bits, 10'b1101001010);

      // Burst of 5 queued while transmitter busy, then drained in order
      clear_logs();
      hold_busy = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         wr_dv = 1'b1; wr_byte = 8'(i + 1);
         @(negedge clk);
      end
      wr_dv = 1'b0;
      chk("burst_count5", count, 5'd5);
      hold_busy = 1'b0;
      wait_idle(5, 1000, "burst_wait");
      chk("burst_issued_n", iss_q.size(), 5);
      for (int i = 0; i < 5 && i < iss_q.size(); i++) begin
         chk($sformatf("burst_byte%0d", i), iss_q[i], 8'(i + 1));
         chk($sformatf("burst_count%0d", i), cnt_q[i], 5'(4 - i));
         if (i > 0) chk($sformatf("burst_after_done%0d", i), fall_q[i], 1'b1);
      end

      // Overflow table with transmitter held busy
      clear_logs();
      hold_busy = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 18; i++) begin
         wr_dv = vecs[i].wr_dv; wr_byte = vecs[i].wr_byte;
         @(negedge clk);
         chk($sformatf("ovf_vec%0d_count", i), count, vecs[i].exp_count);
         chk($sformatf("ovf_vec%0d_full", i), full, vecs[i].exp_full);
         chk($sformatf("ovf_vec%0d_empty", i), empty, vecs[i].exp_empty);
         chk($sformatf("ovf_vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
      end
      wr_dv = 1'b0;
      hold_busy = 1'b0;
      wait_idle(16, 1200, "ovf_drain_wait");
      repeat (60) @(negedge clk);
      chk("ovf_issued_n", iss_q.size(), 16);
      for (int i = 0; i < 16 && i < iss_q.size(); i++)
         chk($sformatf("ovf_byte%0d", i), iss_q[i], 8'h20 + 8'(i));
      chk("ovf_sticky", ovf, 1'b1);
      chk("ovf_drained_empty", empty, 1'b1);

      // Reset clears the sticky overflow
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("ovf_cleared", ovf, 1'b0);

      // Push in the same cycle as a pop with Count=3
      clear_logs();
      hold_busy = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         wr_dv = 1'b1; wr_byte = 8'h41 + 8'(i);
         @(negedge clk);
      end
      wr_dv = 1'b0;
      chk("pp_count3", count, 5'd3);
      hold_busy = 1'b0;
      @(negedge clk);
      chk("pp_count_pre", count, 5'd3);
      chk("pp_no_dv_yet", tx_dv, 1'b0);
      wr_dv = 1'b1; wr_byte = 8'h44;
      @(negedge clk);
      wr_dv = 1'b0;
      chk("pp_dv", tx_dv, 1'b1);
      chk("pp_dv_byte", tx_byte, 8'h41);
      chk("pp_count_same", count, 5'd3);
      wait_idle(4, 800, "pp_wait");
      chk("pp_issued_n", iss_q.size(), 4);
      for (int i = 0; i < 4 && i < iss_q.size(); i++)
         chk($sformatf("pp_byte%0d", i), iss_q[i], 8'h41 + 8'(i));

      // Reset during WAIT_DONE with 4 bytes still queued
      clear_logs();
      hold_busy = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         wr_dv = 1'b1; wr_byte = 8'h51 + 8'(i);
         @(negedge clk);
      end
      wr_dv = 1'b0;
      hold_busy = 1'b0;
      k = 0;
      while (k < 20 && m_state != 1) begin
         @(negedge clk);
         k++;
      end
      chk("rmf_frame_started", (k < 20), 1'b1);
      repeat (3) @(negedge clk);
      chk("rmf_count4", count, 5'd4);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rmf_count0", count, 5'd0);
      chk("rmf_empty", empty, 1'b1);
      chk("rmf_dv0", tx_dv, 1'b0);
      // Push while the interrupted frame is still on the line
      wr_dv = 1'b1; wr_byte = 8'h77;
      @(negedge clk);
      wr_dv = 1'b0;
      wait_idle(2, 600, "rmf_wait");
      repeat (20) @(negedge clk);
      chk("rmf_issued_n", iss_q.size(), 2);
      if (iss_q.size() >= 2) begin
         chk("rmf_first", iss_q[0], 8'h51);
         chk("rmf_new", iss_q[1], 8'h77);
         chk("rmf_new_after_done", fall_q[1], 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global time bound
   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

endmodule
